mult_seq_param: RTL and testbench

Parametrised sequential multiplier computing `a_in * b_in` by repeated addition, with controller and datapath in one block and a two-sided handshake. It generalises the fixed-width repeated-addition multiplier in several ways:
- `WIDTH` is configurable.
- An explicit input-accept handshake is added.
- The smaller operand is always used as the iteration count.
- Signed operation is available as a compile-time option.

It sits between a producer issuing operand pairs and a consumer that takes results.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_seq_datapath.sv | 103 ++++++++++
 rtl/mult_seq_param.sv | 97 +++++++++
 tb/tb_mult_seq_param.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the parametrised sequential multiplier:
//   - STATE_W       : width of the controller state register (2)
//   - DEFAULT_WIDTH : default operand width (8)
//   - state_t       : controller states WAIT=0, CALC=1, DONE=2 (3 is illegal)
// Optional feature macro used by the design files: MULT_SIGNED_EN
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int STATE_W       = 2;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [STATE_W-1:0] {
        WAIT = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_seq_datapath.sv
// ---------------------------------------------------------------------------
// mult_seq_datapath
// Register datapath of the repeated-addition multiplier.
//   A (WIDTH)   : addend, loaded with the larger operand magnitude
//   B (WIDTH)   : down-counter, loaded with the smaller magnitude
//   M (2*WIDTH) : accumulator / product
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   load     in   accept operands: load A/B with compare/swap, clear M
//   step     in   one iteration: M += A, B -= 1
//   finish   in   last CALC cycle (B==0); applies sign fix-up if enabled
//   a_in     in   multiplicand (WIDTH)
//   b_in     in   multiplier (WIDTH)
//   b_zero   out  B == 0
//   m_o      out  accumulator M (2*WIDTH)
// Macro MULT_SIGNED_EN: two's complement operands, magnitudes iterated and
// the product negated on the final CALC edge when the signs differ.
// ---------------------------------------------------------------------------
module mult_seq_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               b_zero,
    output logic [2*WIDTH-1:0] m_o
);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               swap;

`ifdef MULT_SIGNED_EN
    logic neg_q, neg_d;

    // The most negative value negates to itself; read unsigned, that is
    // exactly its magnitude 2^(WIDTH-1).
    assign mag_a = a_in[WIDTH-1] ? -a_in : a_in;
    assign mag_b = b_in[WIDTH-1] ? -b_in : b_in;
`else
    assign mag_a = a_in;
    assign mag_b = b_in;
`endif

    // Smaller magnitude becomes the iteration count; ties keep a_in in A.
    assign swap   = (mag_b > mag_a);
    assign b_zero = (b_q == '0);
    assign m_o    = m_q;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        m_d = m_q;
`ifdef MULT_SIGNED_EN
        neg_d = neg_q;
`endif
        if (load) begin
            a_d = swap ? mag_b : mag_a;
            b_d = swap ? mag_a : mag_b;
            m_d = '0;
`ifdef MULT_SIGNED_EN
            neg_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
`endif
        end else if (step) begin
            m_d = m_q + {{WIDTH{1'b0}}, a_q};
            b_d = b_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (finish) begin
`ifdef MULT_SIGNED_EN
            if (neg_q) begin
                m_d = -m_q;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
            m_q <= '0;
`ifdef MULT_SIGNED_EN
            neg_q <= 1'b0;
`endif
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            m_q <= m_d;
`ifdef MULT_SIGNED_EN
            neg_q <= neg_d;
`endif
        end
    end

endmodule

// File: rtl/mult_seq_param.sv
// ---------------------------------------------------------------------------
// mult_seq_param
// Parametrised sequential multiplier (repeated addition) with an
// input-accept handshake and a result handshake. Holds the WAIT/CALC/DONE
// controller; arithmetic lives in mult_seq_datapath.
// Ports:
//   clk              in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   input_available  in   operands valid on a_in/b_in
//   input_ready      out  high in WAIT
//   a_in             in   multiplicand (WIDTH)
//   b_in             in   multiplier (WIDTH)
//   result_rdy       out  high in DONE, result valid
//   result_taken     in   consumer took the result (sampled in DONE only)
//   result           out  product register M (2*WIDTH)
//   busy             out  high in CALC
// Macro MULT_SIGNED_EN: enables signed (two's complement) operation.
// ---------------------------------------------------------------------------
module mult_seq_param
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               input_available,
    output logic               input_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               result_rdy,
    input  logic               result_taken,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    state_t state_q, state_d;
    logic   load, step, finish, b_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        input_ready = 1'b0;
        result_rdy  = 1'b0;
        busy        = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        case (state_q)
            WAIT: begin
                input_ready = 1'b1;
                if (input_available) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (b_zero) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                result_rdy = 1'b1;
                if (result_taken) begin
                    state_d = WAIT;
                end
            end
            // Encoding 3 is unreachable; recover to WAIT on the next edge.
            default: state_d = WAIT;
        endcase
    end

    mult_seq_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .finish (finish),
        .a_in   (a_in),
        .b_in   (b_in),
        .b_zero (b_zero),
        .m_o    (result)
    );

endmodule

// File: tb/tb_mult_seq_param.sv
module tb_mult_seq_param;

    localparam int W = 8;

    logic             clk;
    logic             reset;
    logic             input_available;
    logic             input_ready;
    logic [W-1:0]     a_in;
    logic [W-1:0]     b_in;
    logic             result_rdy;
    logic             result_taken;
    logic [2*W-1:0]   result;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    mult_seq_param #(.WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .input_available (input_available),
        .input_ready     (input_ready),
        .a_in            (a_in),
        .b_in            (b_in),
        .result_rdy      (result_rdy),
        .result_taken    (result_taken),
        .result          (result),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: operand value as an integer (signed build interprets
    // the top bit as the sign), the product truncated to 2*W bits, and the
    // iteration count as the smaller magnitude.
    function automatic int sval(input logic [W-1:0] v);
`ifdef MULT_SIGNED_EN
        if (v[W-1]) return int'(v) - (1 << W);
`endif
        return int'(v);
    endfunction

    function automatic logic [2*W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [31:0] p;
        p = sval(a) * sval(b);
        return p[2*W-1:0];
    endfunction

    function automatic int model_min(input logic [W-1:0] a, input logic [W-1:0] b);
        int ma, mb;
        ma = sval(a) < 0 ? -sval(a) : sval(a);
        mb = sval(b) < 0 ? -sval(b) : sval(b);
        return (ma < mb) ? ma : mb;
    endfunction

    // One full transaction, entered and left on a falling edge.
    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold, output logic [2*W-1:0] got);
        logic [2*W-1:0] exp;
        int mn, cyc, busy_cnt;
        exp = model_product(a, b);
        mn  = model_min(a, b);
        check_eq("ready_before_accept", input_ready, 1);
        a_in = a;
        b_in = b;
        input_available = 1'b1;
        @(posedge clk);
        cyc = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            input_available = 1'b0;
            cyc++;
            if (busy) busy_cnt++;
        end while (!result_rdy && cyc < 400);
        check_eq("result_rdy_seen", result_rdy, 1);
        check_eq("latency", cyc - 1, mn + 1);
        check_eq("busy_cycles", busy_cnt, mn + 1);
        check_eq("product", result, exp);
        got = result;
        for (int i = 0; i < hold; i++) begin
            input_available = ~input_available;
            a_in = W'($urandom);
            @(negedge clk);
            check_eq("hold_result", result, exp);
            check_eq("hold_ready", input_ready, 0);
            check_eq("hold_rdy", result_rdy, 1);
        end
        input_available = 1'b0;
        result_taken = 1'b1;
        @(negedge clk);
        result_taken = 1'b0;
        check_eq("wait_after_take", input_ready, 1);
        check_eq("rdy_after_take", result_rdy, 0);
        $display("txn a=0x%0h b=0x%0h result=0x%0h expected=0x%0h latency=%0d", a, b, got, exp, cyc - 1);
    endtask

    logic [W-1:0]   ta [5];
    logic [W-1:0]   tb [5];
    logic [2*W-1:0] got;

    initial begin
        reset = 1'b0;
        input_available = 1'b0;
        result_taken = 1'b0;
        a_in = '0;
        b_in = '0;
        #3;
        check_eq("rst_input_ready", input_ready, 1);
        check_eq("rst_result_rdy", result_rdy, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_result", result, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Spec vectors; 7x5 also exercises a long DONE hold.
        ta = '{8'd7, 8'd0,   8'd200, 8'd255, 8'hFD};
        tb = '{8'd5, 8'd200, 8'd0,   8'd255, 8'd7};
        for (int i = 0; i < 5; i++) begin
            do_mult(ta[i], tb[i], (i == 0) ? 10 : 0, got);
`ifndef MULT_SIGNED_EN
            if (i == 0) check_eq("spec_7x5", got, 16'd35);
            if (i == 3) check_eq("spec_255x255", got, 16'hFE01);
            if (i == 4) check_eq("spec_FDx7", got, 16'd1771);
`else
            if (i == 4) check_eq("spec_m3x7", got, 16'hFFEB);
`endif
        end

`ifdef MULT_SIGNED_EN
        do_mult(8'h80, 8'h80, 0, got);
        check_eq("spec_m128xm128", got, 16'h4000);
        do_mult(8'd5, 8'hFF, 0, got);
        check_eq("spec_5xm1", got, 16'hFFFB);
`endif

        // Reset three cycles into CALC of 20x30.
        a_in = 8'd20;
        b_in = 8'd30;
        input_available = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input_available = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("busy_before_abort", busy, 1);
        reset = 1'b0;
        #1;
        check_eq("abort_input_ready", input_ready, 1);
        check_eq("abort_result_rdy", result_rdy, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_result", result, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        $display("txn reset abort during 20x30");
        do_mult(8'd4, 8'd4, 0, got);
        check_eq("after_abort_4x4", got, 16'd16);

        // Randomised operand pairs against the reference model.
        for (int i = 0; i < 16; i++) begin
            do_mult(W'($urandom), W'($urandom_range(0, 63)), $urandom_range(0, 2), got);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
